// File: rtl/cpu_pkg.sv
// Shared CPU constants, fetch state encoding
// and the fetch next-PC helper.
package cpu_pkg;

    localparam int ADDR_W   = 20;
    localparam int INST_W   = 32;
    localparam int HALF_W   = 16;
    localparam int LONG_BIT = 15;

    localparam logic [ADDR_W-1:0] VEC_ADDR = '0;

    typedef enum logic {
        FS_VEC = 1'b0,
        FS_RUN = 1'b1
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] next_pc(
        input logic [ADDR_W-1:0] pc,
        input logic              is_long
    );
        return pc + (is_long ? ADDR_W'(2) : ADDR_W'(1));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus, pipeline controls
// and IF/ID outputs of the fetch stage.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              stall;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ifid_valid;
    logic [INST_W-1:0] ifid_inst;
    logic              ifid_is_long;
    logic [ADDR_W-1:0] ifid_pc;
    logic [ADDR_W-1:0] ifid_next_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  flush,
        input  redirect_valid,
        input  redirect_pc,
        output ifid_valid,
        output ifid_inst,
        output ifid_is_long,
        output ifid_pc,
        output ifid_next_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output stall,
        output flush,
        output redirect_valid,
        output redirect_pc,
        input  ifid_valid,
        input  ifid_inst,
        input  ifid_is_long,
        input  ifid_pc,
        input  ifid_next_pc
    );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: clear drops valid only,
// load captures a new instruction, otherwise hold.
module ifid_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [INST_W-1:0] d_inst,
    input  logic              d_is_long,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [ADDR_W-1:0] d_next_pc,
    output logic              q_valid,
    output logic [INST_W-1:0] q_inst,
    output logic              q_is_long,
    output logic [ADDR_W-1:0] q_pc,
    output logic [ADDR_W-1:0] q_next_pc
);

    // Register update; a cleared slot keeps its stale payload bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid   <= 1'b0;
            q_inst    <= '0;
            q_is_long <= 1'b0;
            q_pc      <= '0;
            q_next_pc <= '0;
        end else if (clear) begin
            q_valid   <= 1'b0;
        end else if (load) begin
            q_valid   <= 1'b1;
            q_inst    <= d_inst;
            q_is_long <= d_is_long;
            q_pc      <= d_pc;
            q_next_pc <= d_next_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: reset-vector load, PC sequencing,
// instruction sizing and IF/ID register control.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    fetch_unit_if.master bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              is_long;
    logic [ADDR_W-1:0] npc;
    logic [INST_W-1:0] inst;
    logic              clear;
    logic              load;

    assign is_long = bus.imem_data[LONG_BIT];
    assign npc     = next_pc(pc_q, is_long);
    assign inst    = is_long ? bus.imem_data :
                     {{(INST_W-HALF_W){1'b0}},
                      bus.imem_data[HALF_W-1:0]};

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_VEC;
            pc_q    <= VEC_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC, memory address and IF/ID controls.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        clear         = 1'b0;
        load          = 1'b0;
        bus.imem_addr = pc_q;
        unique case (state_q)
            FS_VEC: begin
                bus.imem_addr = VEC_ADDR;
                pc_d          = bus.imem_data[ADDR_W-1:0];
                state_d       = FS_RUN;
            end
            FS_RUN: begin
                if (bus.redirect_valid) begin
                    pc_d  = bus.redirect_pc;
                    clear = 1'b1;
                end else if (bus.stall) begin
                    pc_d  = pc_q;
                end else if (bus.flush) begin
                    clear = 1'b1;
                end else begin
                    pc_d  = npc;
                    load  = 1'b1;
                end
            end
            default: begin
                state_d = FS_VEC;
            end
        endcase
    end

    ifid_reg u_ifid (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .d_inst    (inst),
        .d_is_long (is_long),
        .d_pc      (pc_q),
        .d_next_pc (npc),
        .q_valid   (bus.ifid_valid),
        .q_inst    (bus.ifid_inst),
        .q_is_long (bus.ifid_is_long),
        .q_pc      (bus.ifid_pc),
        .q_next_pc (bus.ifid_next_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with
// an instruction-level reference model.
module tb_fetch_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [19:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic        lng;
        logic [19:0] pc;
        logic [19:0] npc;
        logic        all;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:1048575];
    int          mem_gen = 0;
    logic [19:0] rd_a1;

    exp_t  q[$];
    string tq[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    bit          m_run;
    logic [19:0] m_pc;
    logic        m_v;
    logic [31:0] m_inst;
    logic        m_lng;
    logic [19:0] m_ipc;
    logic [19:0] m_inpc;

    // Combinational memory return {M[a+1], M[a]}.
    always @(bus.imem_addr or mem_gen) begin
        rd_a1         = bus.imem_addr + 20'd1;
        bus.imem_data = {mem[rd_a1], mem[bus.imem_addr]};
    end

    task automatic chk(input string name, input string tag,
                       input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s [%s]: got %h, expected %h",
                      name, tag, act, req);
    endtask

    // Monitor: compare DUT outputs after every edge with the queued expectation.
    always @(posedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            string t;
            #1;
            e = q.pop_front();
            t = tq.pop_front();
            chk("imem_addr", t, 32'(bus.imem_addr), 32'(e.addr));
            chk("ifid_valid", t, 32'(bus.ifid_valid), 32'(e.valid));
            if (e.valid || e.all) begin
                chk("ifid_inst", t, bus.ifid_inst, e.inst);
                chk("ifid_is_long", t, 32'(bus.ifid_is_long), 32'(e.lng));
                chk("ifid_pc", t, 32'(bus.ifid_pc), 32'(e.pc));
                chk("ifid_next_pc", t, 32'(bus.ifid_next_pc), 32'(e.npc));
            end
        end
    end

    // Drive one cycle of inputs, advance the model and queue the expectation.
    task automatic step(input bit r, input bit s, input bit f,
                        input bit rv, input logic [19:0] rp,
                        input string tag);
        logic [15:0] w0, w1;
        logic [19:0] a1, nx;
        logic [31:0] vec;
        exp_t        e;
        rst                = r;
        bus.stall          = s;
        bus.flush          = f;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        if (r) begin
            m_run  = 0;
            m_pc   = '0;
            m_v    = 0;
            m_inst = '0;
            m_lng  = 0;
            m_ipc  = '0;
            m_inpc = '0;
        end else if (!m_run) begin
            vec   = {mem[1], mem[0]};
            m_pc  = vec[19:0];
            m_run = 1;
        end else begin
            a1 = m_pc + 20'd1;
            w0 = mem[m_pc];
            w1 = mem[a1];
            nx = m_pc + (w0[15] ? 20'd2 : 20'd1);
            if (rv) begin
                m_pc = rp;
                m_v  = 0;
            end else if (s) begin
            end else if (f) begin
                m_v = 0;
            end else begin
                m_v    = 1;
                m_lng  = w0[15];
                m_inst = w0[15] ? {w1, w0} : {16'h0, w0};
                m_ipc  = m_pc;
                m_inpc = nx;
                m_pc   = nx;
            end
        end
        e.addr  = m_run ? m_pc : 20'h0;
        e.valid = m_v;
        e.inst  = m_inst;
        e.lng   = m_lng;
        e.pc    = m_ipc;
        e.npc   = m_inpc;
        e.all   = r;
        q.push_back(e);
        tq.push_back(tag);
        @(negedge clk);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, tag);
    endtask

    initial begin
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        for (int i = 0; i < 1048576; i++) mem[i] = 16'($urandom);
        mem[0]       = 16'h0040;
        mem[1]       = 16'h0000;
        mem[20'h40]  = 16'h1234;
        mem[20'h41]  = 16'h8001;
        mem[20'h42]  = 16'hBEEF;
        mem[20'h200] = 16'h8123;
        mem[20'hFFFFF] = 16'h8555;
        mem_gen++;
        @(negedge clk);

        step(1, 0, 0, 0, '0, "reset");
        step(0, 1, 1, 1, 20'h00777, "vec");
        run(6, "stream");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0, "stall");
        run(4, "resume");
        step(0, 1, 1, 1, 20'h00100, "redir");
        run(4, "after_redir");
        step(0, 0, 0, 1, 20'hFFFFF, "wrap_long");
        run(3, "wrap_long_run");
        mem[20'hFFFFF] = 16'h1111;
        mem_gen++;
        step(0, 0, 0, 1, 20'hFFFFF, "wrap_short");
        run(3, "wrap_short_run");
        step(0, 0, 1, 0, '0, "flush");
        run(2, "after_flush");
        step(0, 0, 0, 1, 20'h00200, "to_long");
        step(0, 1, 0, 0, '0, "stall_long");
        step(1, 1, 0, 0, '0, "rst_mid");
        step(0, 0, 0, 1, 20'h00300, "vec_redir");
        run(4, "restart");

        for (int i = 0; i < 400; i++) begin
            bit r, s, f, rv;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 25);
            f  = ($urandom_range(0, 99) < 15);
            rv = ($urandom_range(0, 99) < 8);
            step(r, s, f, rv, 20'($urandom_range(0, 20'hFFFFF)), "random");
        end

        rst                = 1'b0;
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("queue_drained", "end", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
